// File: rtl/kt_pkg.sv
// Shared command types for the BLE command path.
// Opcode constants live in cmd[15:12]; the queue itself never decodes them.
package kt_pkg;

    localparam int CMD_W = 16;

    typedef logic [CMD_W-1:0] cmd_t;

    localparam logic [3:0] CMD_OP_CAL  = 4'h2;
    localparam logic [3:0] CMD_OP_MOVE = 4'h4;
    localparam logic [3:0] CMD_OP_TOUR = 4'h5;

endpackage

// File: rtl/cmd_queue_mem.sv
// Command storage for cmd_queue.
// DEPTH x CMD_W register array, synchronous write, asynchronous read, no reset.
module cmd_queue_mem #(
    parameter int DEPTH = 4,
    parameter int CMD_W = 16
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [CMD_W-1:0]         wdata,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [CMD_W-1:0]         rdata
);

    logic [CMD_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/cmd_queue.sv
// Command FIFO between the BLE UART receiver and the tour command mux.
// Optional drop counter port/logic enabled by `CMD_QUEUE_DROP_CNT_EN.
module cmd_queue
    import kt_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CMD_W = kt_pkg::CMD_W
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       uart_rdy,
    input  logic [CMD_W-1:0]           uart_cmd,
    output logic                       uart_clr,
    input  logic                       flush,
    output logic                       cmd_rdy,
    output logic [CMD_W-1:0]           cmd,
    input  logic                       clr_cmd_rdy,
    output logic                       full,
`ifdef CMD_QUEUE_DROP_CNT_EN
    output logic [7:0]                 drop_cnt,
`endif
    output logic [$clog2(DEPTH):0]     count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             guard;
    logic             empty;
    logic             push_req;
    logic             pop;
    logic             do_push;
    logic             do_pop;
    logic             drop;
    logic [CMD_W-1:0] head;

    assign empty    = (count == '0);
    assign full     = (count == CNT_W'(DEPTH));
    assign cmd_rdy  = ~empty;
    assign cmd      = empty ? '0 : head;

    // guard masks the cycle where the receiver has not yet dropped uart_rdy
    assign push_req = uart_rdy & ~guard;
    assign uart_clr = push_req & ~rst;
    assign pop      = clr_cmd_rdy & ~empty;
    assign do_push  = push_req & (~full | pop) & ~flush;
    assign do_pop   = pop & ~flush;
    assign drop     = push_req & full & ~pop & ~flush;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            guard  <= 1'b0;
        end else begin
            guard <= push_req;
            if (flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                count  <= '0;
            end else begin
                if (do_push) begin
                    wr_ptr <= wr_ptr + PTR_W'(1);
                end
                if (do_pop) begin
                    rd_ptr <= rd_ptr + PTR_W'(1);
                end
                if (do_push && !do_pop) begin
                    count <= count + CNT_W'(1);
                end else if (do_pop && !do_push) begin
                    count <= count - CNT_W'(1);
                end
            end
        end
    end

`ifdef CMD_QUEUE_DROP_CNT_EN
    // saturating; only rst clears it so flushes do not hide lost commands
    always_ff @(posedge clk) begin
        if (rst) begin
            drop_cnt <= '0;
        end else if (drop && drop_cnt != 8'hFF) begin
            drop_cnt <= drop_cnt + 8'd1;
        end
    end
`else
    logic unused_drop;
    assign unused_drop = drop;
`endif

    cmd_queue_mem #(
        .DEPTH (DEPTH),
        .CMD_W (CMD_W)
    ) u_mem (
        .clk   (clk),
        .we    (do_push),
        .waddr (wr_ptr),
        .wdata (uart_cmd),
        .raddr (rd_ptr),
        .rdata (head)
    );

endmodule

// File: tb/tb_cmd_queue.sv
// Bench for cmd_queue: directed scenarios plus random traffic against a queue-based model.
module tb_cmd_queue;
    import kt_pkg::*;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        uart_rdy = 1'b0;
    logic [15:0] uart_cmd = '0;
    logic        uart_clr;
    logic        flush = 1'b0;
    logic        cmd_rdy;
    logic [15:0] cmd;
    logic        clr_cmd_rdy = 1'b0;
    logic        full;
    logic [2:0]  count;
`ifdef CMD_QUEUE_DROP_CNT_EN
    logic [7:0]  drop_cnt;
`endif

    always #5 clk = ~clk;

    cmd_queue #(.DEPTH(DEPTH), .CMD_W(16)) dut (
        .clk         (clk),
        .rst         (rst),
        .uart_rdy    (uart_rdy),
        .uart_cmd    (uart_cmd),
        .uart_clr    (uart_clr),
        .flush       (flush),
        .cmd_rdy     (cmd_rdy),
        .cmd         (cmd),
        .clr_cmd_rdy (clr_cmd_rdy),
        .full        (full),
`ifdef CMD_QUEUE_DROP_CNT_EN
        .drop_cnt    (drop_cnt),
`endif
        .count       (count)
    );

    // reference model: plain queue of commands
    cmd_t q[$];
    bit   m_guard = 1'b0;
    int   m_drops = 0;
    int   n_pass = 0;
    int   n_total = 0;
    int   clr_seen = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic check_state();
        cmd_t exp_cmd;
        exp_cmd = (q.size() != 0) ? q[0] : 16'h0;
        check("count", 32'(count), 32'(q.size()));
        check("cmd_rdy", 32'(cmd_rdy), 32'(q.size() != 0));
        check("cmd", 32'(cmd), 32'(exp_cmd));
        check("full", 32'(full), 32'(q.size() == DEPTH));
`ifdef CMD_QUEUE_DROP_CNT_EN
        check("drop_cnt", 32'(drop_cnt), 32'(m_drops));
`endif
    endtask

    task automatic step(input logic r, input logic [15:0] d, input logic p,
                        input logic f, input logic rs);
        bit acc, popv;
        @(negedge clk);
        uart_rdy = r; uart_cmd = d; clr_cmd_rdy = p; flush = f; rst = rs;
        #1;
        acc = r && !m_guard;
        check("uart_clr", 32'(uart_clr), 32'(acc && !rs));
        if (uart_clr) clr_seen++;
        @(posedge clk);
        if (rs) begin
            q.delete();
            m_guard = 1'b0;
            m_drops = 0;
        end else begin
            if (f) begin
                q.delete();
            end else begin
                popv = p && (q.size() != 0);
                if (acc && q.size() == DEPTH && !popv) begin
                    if (m_drops < 255) m_drops++;
                    acc = 1'b1;
                end else begin
                    if (popv) void'(q.pop_front());
                    if (acc) q.push_back(d);
                end
            end
            m_guard = r && !m_guard;
        end
        #1;
        check_state();
    endtask

    // receiver behaviour: rdy stays up one extra cycle after the ack
    task automatic send(input logic [15:0] d);
        step(1'b1, d, 1'b0, 1'b0, 1'b0);
        step(1'b1, d, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic pop1();
        step(1'b0, 16'h0, 1'b1, 1'b0, 1'b0);
    endtask

    initial begin
        logic [15:0] d;
        logic r, p, f, rs;

        // 1: uart_rdy held through the last reset cycle plus two more
        step(1'b0, 16'h0, 1'b0, 1'b0, 1'b1);
        step(1'b1, {CMD_OP_CAL, 12'h000}, 1'b0, 1'b0, 1'b1);
        clr_seen = 0;
        step(1'b1, 16'h2000, 1'b0, 1'b0, 1'b0);
        check("t1_cmd_after_ack", 32'(cmd), 32'h2000);
        step(1'b1, 16'h2000, 1'b0, 1'b0, 1'b0);
        check("t1_one_clr", 32'(clr_seen), 32'd1);
        pop1();

        // 2: FIFO order
        send({CMD_OP_MOVE, 12'h001});
        send(16'h4002);
        send(16'h4003);
        check("t2_head", 32'(cmd), 32'h4001);
        pop1();
        check("t2_head2", 32'(cmd), 32'h4002);
        pop1();
        pop1();
        pop1();
        check("t2_empty_cmd", 32'(cmd), 32'h0);

        // 3: overflow drop
        for (int i = 0; i < 5; i++) send(16'h5000 + 16'(i));
        check("t3_full", 32'(full), 32'd1);
        for (int i = 0; i < 4; i++) begin
            check("t3_pop_order", 32'(cmd), 32'h5000 + 32'(i));
            pop1();
        end

        // 4: push and pop together while full
        for (int i = 0; i < 4; i++) send(16'h6000 + 16'(i));
        step(1'b1, 16'h6006, 1'b1, 1'b0, 1'b0);
        step(1'b1, 16'h6006, 1'b0, 1'b0, 1'b0);
        check("t4_count", 32'(count), 32'd4);
        for (int i = 0; i < 3; i++) pop1();
        check("t4_last", 32'(cmd), 32'h6006);
        pop1();

        // 5: flush with simultaneous push and pop
        for (int i = 0; i < 3; i++) send(16'h7000 + 16'(i));
        step(1'b1, 16'h7007, 1'b1, 1'b1, 1'b0);
        check("t5_cmd_rdy", 32'(cmd_rdy), 32'd0);
        step(1'b1, 16'h7007, 1'b0, 1'b0, 1'b0);
        send({CMD_OP_TOUR, 12'h100});
        check("t5_next_head", 32'(cmd), 32'h5100);
        pop1();

        // 6: pointer wrap with occupancy 2-3, then reset mid-stream
        for (int i = 0; i < 10; i++) begin
            d = 16'($urandom);
            step(1'b1, d, q.size() >= 3, 1'b0, 1'b0);
            step(1'b1, d, 1'b0, 1'b0, 1'b0);
        end
        step(1'b1, 16'h1234, 1'b0, 1'b0, 1'b1);
        check("t6_rst_count", 32'(count), 32'd0);
        step(1'b1, 16'h1234, 1'b0, 1'b0, 1'b0);
        check("t6_reaccept", 32'(cmd), 32'h1234);

        // random traffic
        for (int i = 0; i < 600; i++) begin
            r  = ($urandom_range(0, 3) != 0);
            p  = ($urandom_range(0, 2) == 0);
            f  = ($urandom_range(0, 31) == 0);
            rs = ($urandom_range(0, 127) == 0);
            step(r, 16'($urandom), p, f, rs);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
